op_dispatcher: RTL
==================

Name: op_dispatcher

Overview:
- Sequences parsed G-code ops into the op handlers, one op at a time.
- Takes an Op_st from the op reader over a valid/ready handshake and latches it.
- Pulses the trigger of the selected handler (linear, circular or dummy) and waits for that handler's done.
- Tracks absolute/relative mode (G90/G91) and counts completed ops.
- Sits between the op reader/parser and the handler bank, above the handler input-select logic.

Parameters:
- CNT_W, 16, width of the completed-op counter.
- TIMEOUT_CYCLES, 2000000, watchdog limit in clk cycles. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  when low, no new op is accepted; an in-flight op still completes
- op_in  in  Op_st  op from the op reader
- op_valid  in  1  op_in is valid
- op_ready  out  1  dispatcher can accept an op
- op_out  out  Op_st  latched op, driven to all handlers
- lin_trigger  out  1  start pulse to the linear handler (G00/G01)
- lin_done  in  1  linear handler finished
- circ_trigger  out  1  start pulse to the circular handler (G02/G03)
- circ_done  in  1  circular handler finished
- dummy_trigger  out  1  start pulse to the dummy handler (G90/G91/unsupported)
- dummy_done  in  1  dummy handler finished
- abs_mode  out  1  1 = absolute (G90), 0 = relative (G91)
- busy  out  1  an op is in flight
- op_count  out  CNT_W  number of completed ops, wraps modulo 2^CNT_W
- timeout_err  out  1  sticky watchdog error; exists only with the macro

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high.
- Reset values:
  - FSM in IDLE; op_ready=0, all triggers=0, busy=0.
  - op_out=all zeros; abs_mode=1; op_count=0; timeout_err=0.
- FSM states: IDLE, DISPATCH, WAIT.
- IDLE:
  - op_ready = enable.
  - On op_valid & op_ready: latch op_in into op_out, decode the target handler, go to DISPATCH.
- DISPATCH (exactly one cycle):
  - Assert exactly one trigger for one cycle; busy=1; op_ready=0.
  - Target handler: G00/G01 -> lin; G02/G03 -> circ; G90/G91 and any other cmd -> dummy.
  - If the cmd is G90 or G91, abs_mode updates to 1 or 0 at the end of this cycle.
  - If the selected handler's done is already high in this cycle, go straight to IDLE with completion. Otherwise go to WAIT.
- WAIT:
  - Triggers low, busy=1.
  - Only the selected handler's done is honoured; done from the other handlers is ignored.
  - On the selected done: op_count += 1, go to IDLE.
- Completion latency:
  - Op accepted at cycle N -> trigger high at N+1.
  - Selected done first high at cycle M (M >= N+1) -> busy=0 and op_ready=enable at M+1.
  - Best-case back-to-back throughput: 1 op per 2 cycles.
- op_out is stable from DISPATCH until the next accept; handlers may sample it at any point during the op.
- Deasserting enable mid-op has no effect on the in-flight op. It blocks only the next accept.
- op_valid while busy: op_ready stays 0 and the op is held by the source.
- op_count wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-op: the FSM returns to IDLE at once and triggers drop in the same cycle. Handlers are reset by the same signal; a late done after reset is ignored.

Optional Feature:
- Macro: OP_DISPATCH_TIMEOUT_EN.
- With the macro:
  - A cycle counter clears on entry to DISPATCH and increments in WAIT.
  - When it reaches TIMEOUT_CYCLES, set timeout_err (sticky, cleared only by reset) and go to IDLE without incrementing op_count.
  - The dispatcher stays blocked (op_ready=0) while timeout_err=1.
- Without the macro: no counter, no timeout_err port, and WAIT lasts indefinitely.

Decomposition:
- Op_PKG (existing): Op_st and the OP_CMD_G00/G01/G02/G03/G90/G91 constants.
- Add to Op_PKG: an enum OpHandlerSel_e (SEL_LIN, SEL_CIRC, SEL_DUMMY) and a function cmd_to_sel(cmd).
- Sub-module op_cmd_decoder: combinational cmd -> OpHandlerSel_e plus is_abs/is_rel flags. It is instantiated once, on op_in at accept time, and its result is registered.

Test Plan:
- Reset checks: after reset, abs_mode=1, op_count=0, all triggers=0, busy=0; op_ready=1 with enable=1.
- Linear op: send G01 at cycle N -> lin_trigger=1 only at N+1; hold lin_done low 5 cycles then pulse it -> op_count=1 and op_ready=1 the cycle after done.
- Mode ops: send G91 with dummy_done tied high -> dummy_trigger pulse, abs_mode=0, op_ready back after 2 cycles. Send G90 -> abs_mode=1.
- Wrong-handler done: send G02, pulse lin_done and dummy_done in WAIT -> ignored, busy stays 1. Pulse circ_done -> completes, op_count increments.
- Enable and reset mid-op: drop enable during WAIT of G00 -> op completes but no new accept while op_valid=1. Assert reset mid-WAIT -> triggers low, IDLE, op_count=0.
- Timeout (OP_DISPATCH_TIMEOUT_EN, TIMEOUT_CYCLES=20): send G00 with lin_done never high -> timeout_err=1, op_ready stays 0, op_count unchanged.

Source files
------------

// File: rtl/Op_PKG.sv
// rtl/Op_PKG.sv - op record, G-code command constants and handler-select helpers
package Op_PKG;

    localparam int OP_CMD_W = 8;

    localparam logic [OP_CMD_W-1:0] OP_CMD_G00 = 8'd0;
    localparam logic [OP_CMD_W-1:0] OP_CMD_G01 = 8'd1;
    localparam logic [OP_CMD_W-1:0] OP_CMD_G02 = 8'd2;
    localparam logic [OP_CMD_W-1:0] OP_CMD_G03 = 8'd3;
    localparam logic [OP_CMD_W-1:0] OP_CMD_G90 = 8'd90;
    localparam logic [OP_CMD_W-1:0] OP_CMD_G91 = 8'd91;

    typedef struct packed {
        logic [OP_CMD_W-1:0] cmd;
        logic [15:0]         x;
        logic [15:0]         y;
        logic [15:0]         i;
        logic [15:0]         j;
    } Op_st;

    typedef enum logic [1:0] {
        SEL_LIN   = 2'd0,
        SEL_CIRC  = 2'd1,
        SEL_DUMMY = 2'd2
    } OpHandlerSel_e;

    // Mode changes and unknown commands go to the dummy handler.
    function automatic OpHandlerSel_e cmd_to_sel(input logic [OP_CMD_W-1:0] cmd);
        OpHandlerSel_e sel;
        case (cmd)
            OP_CMD_G00, OP_CMD_G01: sel = SEL_LIN;
            OP_CMD_G02, OP_CMD_G03: sel = SEL_CIRC;
            default:                sel = SEL_DUMMY;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/op_cmd_decoder.sv
// rtl/op_cmd_decoder.sv - combinational cmd decode to handler select and mode flags
module op_cmd_decoder
    import Op_PKG::*;
(
    input  logic [OP_CMD_W-1:0] cmd_i,
    output OpHandlerSel_e       sel_o,
    output logic                is_abs_o,
    output logic                is_rel_o
);

    assign sel_o    = cmd_to_sel(cmd_i);
    assign is_abs_o = (cmd_i == OP_CMD_G90);
    assign is_rel_o = (cmd_i == OP_CMD_G91);

endmodule

// File: rtl/op_dispatcher.sv
// rtl/op_dispatcher.sv - sequences ops into lin/circ/dummy handlers; watchdog under OP_DISPATCH_TIMEOUT_EN
module op_dispatcher
    import Op_PKG::*;
#(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  Op_st             op_in,
    input  logic             op_valid,
    output logic             op_ready,
    output Op_st             op_out,
    output logic             lin_trigger,
    input  logic             lin_done,
    output logic             circ_trigger,
    input  logic             circ_done,
    output logic             dummy_trigger,
    input  logic             dummy_done,
    output logic             abs_mode,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
`ifdef OP_DISPATCH_TIMEOUT_EN
    ,
    output logic             timeout_err
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_DISPATCH, ST_WAIT} state_e;

    state_e           state_q, state_d;
    Op_st             op_q, op_d;
    OpHandlerSel_e    sel_q, sel_d;
    logic             is_abs_q, is_abs_d, is_rel_q, is_rel_d;
    logic             abs_q, abs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blocked;
    logic             sel_done;

    OpHandlerSel_e    dec_sel;
    logic             dec_abs, dec_rel;

    op_cmd_decoder u_dec (
        .cmd_i    (op_in.cmd),
        .sel_o    (dec_sel),
        .is_abs_o (dec_abs),
        .is_rel_o (dec_rel)
    );

`ifdef OP_DISPATCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    assign blocked     = err_q;
    assign timeout_err = err_q;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES == 0);
    assign blocked    = 1'b0;
`endif

    // Done from a handler that was not triggered is ignored.
    always_comb begin
        sel_done = 1'b0;
        case (sel_q)
            SEL_LIN:   sel_done = lin_done;
            SEL_CIRC:  sel_done = circ_done;
            SEL_DUMMY: sel_done = dummy_done;
            default:   sel_done = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sel_d    = sel_q;
        is_abs_d = is_abs_q;
        is_rel_d = is_rel_q;
        abs_d    = abs_q;
        cnt_d    = cnt_q;
`ifdef OP_DISPATCH_TIMEOUT_EN
        tmo_d    = tmo_q;
        err_d    = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (op_valid && enable && !blocked) begin
                    op_d     = op_in;
                    sel_d    = dec_sel;
                    is_abs_d = dec_abs;
                    is_rel_d = dec_rel;
                    state_d  = ST_DISPATCH;
`ifdef OP_DISPATCH_TIMEOUT_EN
                    tmo_d    = '0;
`endif
                end
            end
            ST_DISPATCH: begin
                if (is_abs_q)      abs_d = 1'b1;
                else if (is_rel_q) abs_d = 1'b0;
                if (sel_done) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sel_done) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_IDLE;
                end
`ifdef OP_DISPATCH_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            sel_q    <= SEL_DUMMY;
            is_abs_q <= 1'b0;
            is_rel_q <= 1'b0;
            abs_q    <= 1'b1;
            cnt_q    <= '0;
`ifdef OP_DISPATCH_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sel_q    <= sel_d;
            is_abs_q <= is_abs_d;
            is_rel_q <= is_rel_d;
            abs_q    <= abs_d;
            cnt_q    <= cnt_d;
`ifdef OP_DISPATCH_TIMEOUT_EN
            tmo_q    <= tmo_d;
            err_q    <= err_d;
`endif
        end
    end

    // Gated by reset so triggers drop in the cycle reset is raised.
    assign lin_trigger   = !reset && (state_q == ST_DISPATCH) && (sel_q == SEL_LIN);
    assign circ_trigger  = !reset && (state_q == ST_DISPATCH) && (sel_q == SEL_CIRC);
    assign dummy_trigger = !reset && (state_q == ST_DISPATCH) && (sel_q == SEL_DUMMY);
    assign op_ready      = !reset && (state_q == ST_IDLE) && enable && !blocked;
    assign busy          = (state_q != ST_IDLE);
    assign op_out        = op_q;
    assign abs_mode      = abs_q;
    assign op_count      = cnt_q;

endmodule
